cu_cmd_issuer: RTL and testbench

Command initiator for the control-unit decode path. Accepts one command at a time from an upstream sequencer. Encodes the command into the unit-select and control fields that the control-unit decoder consumes, then strobes them with setup and hold cycles. Waits for the addressed unit's acknowledge, with a bounded timeout and optional retry, and reports completion or error upstream.

---
 rtl/cu_cmd_issuer.sv | 187 ++++++++++++++++++
 tb/tb_cu_cmd_issuer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cu_cmd_issuer.sv
// Command issuer for the control-unit decode path: encodes a command into sel/ctl, strobes it
// with setup/hold cycles, waits for ack with a bounded timeout. Optional retry: CU_CMD_ISSUER_RETRY_EN.
module cu_cmd_issuer #(
    parameter int TIMEOUT = 15,
    parameter int RETRIES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [2:0] req_op,
    input  logic [1:0] req_unit,
    output logic       req_ready,
    output logic [1:0] sel,
    output logic [4:0] ctl,
    output logic       cmd_stb,
    input  logic       ack,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [1:0]      ERR_ILLEGAL = 2'd1;
    localparam logic [1:0]      ERR_TIMEOUT = 2'd2;
    localparam logic [2:0]      OP_NOP      = 3'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_REPORT
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [4:0]    ctl_q, ctl_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          res_err_q, res_err_d;
    logic [1:0]    err_code_q, err_code_d;

    logic          op_legal;
    logic [4:0]    op_ctl;

    // Opcode table: control field {c,d,e,f,o}; opcodes 5..7 are illegal.
    always_comb begin
        op_legal = 1'b1;
        op_ctl   = 5'b00000;
        case (req_op)
            3'd0:    op_ctl = 5'b00000;
            3'd1:    op_ctl = 5'b00010;
            3'd2:    op_ctl = 5'b10111;
            3'd3:    op_ctl = 5'b00100;
            3'd4:    op_ctl = 5'b01001;
            default: op_legal = 1'b0;
        endcase
    end

`ifdef CU_CMD_ISSUER_RETRY_EN
    localparam logic [2:0] RMAX = 3'(RETRIES);
    logic [2:0] retry_q, retry_d;
`else
    logic unused_retries;
    assign unused_retries = ^RETRIES;
`endif

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ctl_d      = ctl_q;
        timer_d    = timer_q;
        res_err_d  = res_err_q;
        err_code_d = err_code_q;
`ifdef CU_CMD_ISSUER_RETRY_EN
        retry_d    = retry_q;
`endif
        req_ready  = 1'b0;
        sel        = 2'b00;
        ctl        = 5'b00000;
        cmd_stb    = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        err_code   = 2'b00;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    sel_d      = req_unit;
                    timer_d    = '0;
                    res_err_d  = 1'b0;
                    err_code_d = 2'b00;
`ifdef CU_CMD_ISSUER_RETRY_EN
                    retry_d    = 3'd0;
`endif
                    if (!op_legal) begin
                        ctl_d      = 5'b00000;
                        res_err_d  = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                        state_d    = S_REPORT;
                    end else if (req_op == OP_NOP) begin
                        ctl_d   = 5'b00000;
                        state_d = S_REPORT;
                    end else begin
                        ctl_d   = op_ctl;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                sel     = sel_q;
                ctl     = ctl_q;
                timer_d = '0;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                sel     = sel_q;
                ctl     = ctl_q;
                cmd_stb = 1'b1;
                timer_d = timer_q + TW'(1);
                // ack on the final strobe cycle still counts as success
                if (ack) begin
                    res_err_d = 1'b0;
                    state_d   = S_HOLD;
                end else if (timer_q == TMO_LAST) begin
`ifdef CU_CMD_ISSUER_RETRY_EN
                    if (retry_q < RMAX) begin
                        retry_d = retry_q + 3'd1;
                        state_d = S_SETUP;
                    end else begin
                        res_err_d  = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                        state_d    = S_HOLD;
                    end
`else
                    res_err_d  = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_HOLD;
`endif
                end
            end
            S_HOLD: begin
                sel     = sel_q;
                ctl     = ctl_q;
                state_d = S_REPORT;
            end
            S_REPORT: begin
                done     = !res_err_q;
                err      = res_err_q;
                err_code = res_err_q ? err_code_q : 2'b00;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from state, so an asynchronous reset drops the strobe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= 2'b00;
            ctl_q      <= 5'b00000;
            timer_q    <= '0;
            res_err_q  <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ctl_q      <= ctl_d;
            timer_q    <= timer_d;
            res_err_q  <= res_err_d;
            err_code_q <= err_code_d;
        end
    end

`ifdef CU_CMD_ISSUER_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= 3'd0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

endmodule

// File: tb/tb_cu_cmd_issuer.sv
// Self-checking bench for cu_cmd_issuer (TIMEOUT=3, RETRIES=2): table-driven commands plus
// hand-written sequences for reset abort and back-to-back NOP/UNIT_WR.
module tb_cu_cmd_issuer;

    localparam int TMO = 3;
    localparam int RET = 2;
`ifdef CU_CMD_ISSUER_RETRY_EN
    localparam int N_BURST = RET + 1;
`else
    localparam int N_BURST = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] req_op;
    logic [1:0] req_unit;
    logic       req_ready;
    logic [1:0] sel;
    logic [4:0] ctl;
    logic       cmd_stb;
    logic       ack;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    int n_cmp = 0;
    int n_err = 0;

    cu_cmd_issuer #(.TIMEOUT(TMO), .RETRIES(RET)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_unit  (req_unit),
        .req_ready (req_ready),
        .sel       (sel),
        .ctl       (ctl),
        .cmd_stb   (cmd_stb),
        .ack       (ack),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] op;
        logic [1:0] unit;
        int         ack_at;   // strobe cycle within a burst that sees ack=1; 0 = never
        logic [1:0] e_sel;    // fields seen in cycle 1 (SETUP) - 0 for NOP/illegal
        logic [4:0] e_ctl;
        int         e_rep;    // cycle of done/err pulse, acceptance = cycle 0
        logic       e_done;
        logic       e_err;
        logic [1:0] e_code;
        int         e_stb;    // total strobe cycles
        int         e_bursts;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issues one command starting in an IDLE cycle and watches it to the following IDLE cycle.
    task automatic run_cmd(input vec_t v, input string tag);
        int rep_cyc, rdy_cyc, n_stb, n_burst, in_burst;
        int bad_field, bad_both, bad_ready;
        logic prev_stb, got_done, got_err;
        logic [1:0] got_code, s1;
        logic [4:0] c1;
        rep_cyc = -1; rdy_cyc = -1; n_stb = 0; n_burst = 0; in_burst = 0;
        bad_field = 0; bad_both = 0; bad_ready = 0;
        prev_stb = 1'b0; got_done = 1'b0; got_err = 1'b0; got_code = 2'b00;
        s1 = 2'b00; c1 = 5'b00000;
        chk({tag, ".ready_at_accept"}, req_ready, 1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_unit  = v.unit;
        ack       = 1'b0;
        for (int cyc = 1; cyc <= 80 && rdy_cyc < 0; cyc++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            if (cyc == 1) begin
                s1 = sel;
                c1 = ctl;
            end
            if (cmd_stb) begin
                n_stb++;
                if (!prev_stb) begin
                    n_burst++;
                    in_burst = 1;
                end else begin
                    in_burst++;
                end
                if (sel !== s1 || ctl !== c1) bad_field++;
            end
            prev_stb = cmd_stb;
            ack = cmd_stb && (in_burst == v.ack_at);
            if (done && err) bad_both++;
            if (rep_cyc < 0) begin
                if (done || err) begin
                    rep_cyc  = cyc;
                    got_done = done;
                    got_err  = err;
                    got_code = err_code;
                    if (sel !== 2'b00 || ctl !== 5'b00000) bad_field++;
                end
                if (req_ready) bad_ready++;
            end else if (req_ready) begin
                rdy_cyc = cyc;
            end
        end
        ack = 1'b0;
        chk({tag, ".report_cycle"}, rep_cyc, v.e_rep);
        chk({tag, ".done"}, got_done, v.e_done);
        chk({tag, ".err"}, got_err, v.e_err);
        if (v.e_err) chk({tag, ".err_code"}, got_code, v.e_code);
        chk({tag, ".ready_cycle"}, rdy_cyc, v.e_rep + 1);
        chk({tag, ".sel"}, s1, v.e_sel);
        chk({tag, ".ctl"}, c1, v.e_ctl);
        chk({tag, ".strobe_cycles"}, n_stb, v.e_stb);
        chk({tag, ".bursts"}, n_burst, v.e_bursts);
        chk({tag, ".field_glitches"}, bad_field, 0);
        chk({tag, ".done_and_err"}, bad_both, 0);
        chk({tag, ".ready_while_busy"}, bad_ready, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".req_ready"}, req_ready, 1);
        chk({tag, ".sel"}, sel, 0);
        chk({tag, ".ctl"}, ctl, 0);
        chk({tag, ".cmd_stb"}, cmd_stb, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".err"}, err, 0);
        chk({tag, ".err_code"}, err_code, 0);
    endtask

    initial begin
        vec_t post;
        // op, unit, ack_at, sel, ctl, rep, done, err, code, stb, bursts
        vecs[0] = '{3'd1, 2'b10, 1, 2'b10, 5'b00010, 4, 1'b1, 1'b0, 2'd0, 1, 1};
        vecs[1] = '{3'd2, 2'b01, 0, 2'b01, 5'b10111, N_BURST * (TMO + 1) + 2, 1'b0, 1'b1, 2'd2,
                    N_BURST * TMO, N_BURST};
        vecs[2] = '{3'd6, 2'b11, 0, 2'b00, 5'b00000, 1, 1'b0, 1'b1, 2'd1, 0, 0};
        vecs[3] = '{3'd4, 2'b11, TMO, 2'b11, 5'b01001, TMO + 3, 1'b1, 1'b0, 2'd0, TMO, 1};
        vecs[4] = '{3'd0, 2'b01, 0, 2'b00, 5'b00000, 1, 1'b1, 1'b0, 2'd0, 0, 0};
        vecs[5] = '{3'd3, 2'b00, 2, 2'b00, 5'b00100, 5, 1'b1, 1'b0, 2'd0, 2, 1};
        vecs[6] = '{3'd5, 2'b10, 0, 2'b00, 5'b00000, 1, 1'b0, 1'b1, 2'd1, 0, 0};
        vecs[7] = '{3'd2, 2'b11, 1, 2'b11, 5'b10111, 4, 1'b1, 1'b0, 2'd0, 1, 1};
        vecs[8] = '{3'd7, 2'b01, 0, 2'b00, 5'b00000, 1, 1'b0, 1'b1, 2'd1, 0, 0};
        post    = '{3'd4, 2'b01, 1, 2'b01, 5'b01001, 4, 1'b1, 1'b0, 2'd0, 1, 1};

        // reset
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_unit = 2'b00; ack = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i], $sformatf("v%0d", i));
        end

        // reset mid-strobe of CLEAR aborts at once, with no report afterwards
        req_valid = 1'b1; req_op = 3'd3; req_unit = 2'b01;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort.strobe_before_reset", cmd_stb, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("abort.no_report_%0d", k), done | err | cmd_stb, 0);
        end
        run_cmd(post, "gate_after_reset");

        // NOP back-to-back with UNIT_WR, req_valid held high, ack held high throughout
        req_valid = 1'b1; req_op = 3'd0; req_unit = 2'b01; ack = 1'b1;
        @(posedge clk); #1;                          // cycle 1: NOP report
        chk("b2b.nop_done", done, 1);
        chk("b2b.nop_stb", cmd_stb, 0);
        chk("b2b.nop_ready", req_ready, 0);
        req_op = 3'd1; req_unit = 2'b10;
        @(posedge clk); #1;                          // cycle 2: accept UNIT_WR
        chk("b2b.accept_ready", req_ready, 1);
        chk("b2b.accept_done", done, 0);
        @(posedge clk); #1;                          // cycle 3: SETUP, ack ignored
        chk("b2b.setup_stb", cmd_stb, 0);
        chk("b2b.setup_sel", sel, 2'b10);
        chk("b2b.setup_ctl", ctl, 5'b00010);
        req_op = 3'd2;
        @(posedge clk); #1;                          // cycle 4: STROBE
        chk("b2b.strobe", cmd_stb, 1);
        chk("b2b.strobe_ready", req_ready, 0);
        @(posedge clk); #1;                          // cycle 5: HOLD
        chk("b2b.hold_stb", cmd_stb, 0);
        chk("b2b.hold_done", done, 0);
        chk("b2b.hold_ctl", ctl, 5'b00010);
        @(posedge clk); #1;                          // cycle 6: REPORT
        chk("b2b.done", done, 1);
        chk("b2b.err", err, 0);
        chk("b2b.report_ctl", ctl, 0);
        req_valid = 1'b0; ack = 1'b0;
        @(posedge clk); #1;                          // cycle 7: IDLE
        chk("b2b.idle_ready", req_ready, 1);
        @(posedge clk); #1;                          // cycle 8: still IDLE, nothing queued
        chk("b2b.not_queued_ready", req_ready, 1);
        chk("b2b.not_queued_stb", cmd_stb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
